// File: rtl/gyro_loop_sequencer.sv
// Run controller for the gyro tester DTX/DRX datapath: latches a loop
// configuration, flushes the FIFOs, opens RX ahead of TX, counts words and
// reports done / timeout / overrun / config-error events.
module gyro_loop_sequencer #(
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned FLUSH_CYC   = 8,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned TO_W        = 13
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             start,
    input  logic             restart,
    input  logic [2:0]       cfg_mode,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             tx_beat,
    input  logic             rx_beat,
    output logic [2:0]       mode_sel,
    output logic             flush,
    output logic             rx_en,
    output logic             tx_en,
    output logic             busy,
    output logic [LEN_W-1:0] tx_count,
    output logic [LEN_W-1:0] rx_count,
    output logic             done_pulse,
    output logic             timeout_pulse,
    output logic             overrun_pulse,
    output logic             cfg_err_pulse,
    output logic [2:0]       state_o
);

    localparam int unsigned FC_W = $clog2(FLUSH_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_ARM   = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [2:0]       r_mode_sel;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_tx_count;
    logic [LEN_W-1:0] r_rx_count;
    logic [FC_W-1:0]  r_fcnt;
    logic [TO_W-1:0]  r_idle;
    logic             r_flush;
    logic             r_rx_en;
    logic             r_tx_en;
    logic             r_busy;
    logic             r_done;
    logic             r_to;
    logic             r_ovr;
    logic             r_cerr;

    logic [2:0]       w_mode_nxt;
    logic [LEN_W-1:0] w_len_nxt;
    logic [LEN_W-1:0] w_tx_cnt_nxt;
    logic [LEN_W-1:0] w_rx_cnt_nxt;
    logic [FC_W-1:0]  w_fcnt_nxt;
    logic [TO_W-1:0]  w_idle_nxt;
    logic             w_ovr_nxt;
    logic             w_to_nxt;
    logic             w_cerr_nxt;
    logic             w_flush_nxt;
    logic             w_rx_en_nxt;
    logic             w_tx_en_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    logic             w_tx_hit;
    logic             w_rx_hit;
    logic             w_cfg_ok;
    logic             w_launch;

    // Beats only count while the matching path is enabled
    assign w_tx_hit = tx_beat & r_tx_en;
    assign w_rx_hit = rx_beat & r_rx_en;
    assign w_cfg_ok = (cfg_len != '0) && (cfg_mode <= 3'd5);
    assign w_launch = restart | (start & (r_state == S_IDLE));

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, word counters and event detection; restart/start override last
    always_comb begin
        w_state_nxt  = r_state;
        w_fcnt_nxt   = '0;
        w_idle_nxt   = '0;
        w_mode_nxt   = r_mode_sel;
        w_len_nxt    = r_len;
        w_tx_cnt_nxt = r_tx_count;
        w_rx_cnt_nxt = r_rx_count;
        w_ovr_nxt    = 1'b0;
        w_to_nxt     = 1'b0;
        w_cerr_nxt   = 1'b0;

        if (w_tx_hit && (r_tx_count != r_len)) begin
            w_tx_cnt_nxt = r_tx_count + LEN_W'(1);
        end
        if (w_rx_hit) begin
            if (r_rx_count == r_len) begin
                w_ovr_nxt = 1'b1;
            end else begin
                w_rx_cnt_nxt = r_rx_count + LEN_W'(1);
            end
        end

        case (r_state)
            S_IDLE: begin
            end
            S_FLUSH: begin
                if (r_fcnt == FC_W'(FLUSH_CYC - 1)) begin
                    w_state_nxt = S_ARM;
                end else begin
                    w_fcnt_nxt = r_fcnt + FC_W'(1);
                end
            end
            S_ARM: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_tx_cnt_nxt == r_len) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_rx_hit) begin
                    w_idle_nxt = '0;
                end else if (r_idle != TO_W'(TIMEOUT_CYC)) begin
                    w_idle_nxt = r_idle + TO_W'(1);
                end else begin
                    w_idle_nxt = r_idle;
                end
                // Completion wins over a timeout expiring in the same cycle
                if (w_rx_cnt_nxt == r_len) begin
                    w_state_nxt = S_DONE;
                end else if (w_idle_nxt == TO_W'(TIMEOUT_CYC)) begin
                    w_state_nxt = S_IDLE;
                    w_to_nxt    = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_launch) begin
            w_fcnt_nxt = '0;
            w_idle_nxt = '0;
            w_ovr_nxt  = 1'b0;
            w_to_nxt   = 1'b0;
            if (w_cfg_ok) begin
                w_state_nxt  = S_FLUSH;
                w_mode_nxt   = cfg_mode;
                w_len_nxt    = cfg_len;
                w_tx_cnt_nxt = '0;
                w_rx_cnt_nxt = '0;
            end else begin
                w_state_nxt = S_IDLE;
                w_cerr_nxt  = 1'b1;
                // An aborted run loses its counts; a rejected start from idle keeps them
                if (r_state != S_IDLE) begin
                    w_tx_cnt_nxt = '0;
                    w_rx_cnt_nxt = '0;
                end
            end
        end
    end

    // Output decode from the upcoming state so enables line up with the state
    always_comb begin
        w_flush_nxt = (w_state_nxt == S_FLUSH);
        w_rx_en_nxt = (w_state_nxt == S_ARM) || (w_state_nxt == S_RUN) ||
                      (w_state_nxt == S_DRAIN);
        w_tx_en_nxt = (w_state_nxt == S_RUN);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_done_nxt  = (w_state_nxt == S_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_mode_sel <= '0;
            r_len      <= '0;
            r_tx_count <= '0;
            r_rx_count <= '0;
            r_fcnt     <= '0;
            r_idle     <= '0;
            r_flush    <= 1'b0;
            r_rx_en    <= 1'b0;
            r_tx_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_to       <= 1'b0;
            r_ovr      <= 1'b0;
            r_cerr     <= 1'b0;
        end else begin
            r_mode_sel <= w_mode_nxt;
            r_len      <= w_len_nxt;
            r_tx_count <= w_tx_cnt_nxt;
            r_rx_count <= w_rx_cnt_nxt;
            r_fcnt     <= w_fcnt_nxt;
            r_idle     <= w_idle_nxt;
            r_flush    <= w_flush_nxt;
            r_rx_en    <= w_rx_en_nxt;
            r_tx_en    <= w_tx_en_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_to       <= w_to_nxt;
            r_ovr      <= w_ovr_nxt;
            r_cerr     <= w_cerr_nxt;
        end
    end

    assign mode_sel      = r_mode_sel;
    assign flush         = r_flush;
    assign rx_en         = r_rx_en;
    assign tx_en         = r_tx_en;
    assign busy          = r_busy;
    assign tx_count      = r_tx_count;
    assign rx_count      = r_rx_count;
    assign done_pulse    = r_done;
    assign timeout_pulse = r_to;
    assign overrun_pulse = r_ovr;
    assign cfg_err_pulse = r_cerr;
    assign state_o       = r_state;

endmodule

// File: tb/tb_gyro_loop_sequencer.sv
// Bench for gyro_loop_sequencer: random beat traffic against an event-time
// reference model; expected pulse events go into a queue that a negedge
// monitor drains whenever the DUT raises a pulse.
module tb_gyro_loop_sequencer;

    localparam int LEN_W       = 16;
    localparam int FLUSH_CYC   = 8;
    localparam int TIMEOUT_CYC = 4096;
    localparam int TO_W        = 13;

    localparam int EV_OVR  = 1;
    localparam int EV_DONE = 2;
    localparam int EV_TO   = 3;
    localparam int EV_CERR = 4;

    typedef struct {
        int kind;
        int edge_n;
        int txc;
        int rxc;
    } ev_t;

    logic             ACLK = 1'b0;
    logic             ARESET = 1'b1;
    logic             start = 1'b0;
    logic             restart = 1'b0;
    logic [2:0]       cfg_mode = 3'd0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             tx_beat = 1'b0;
    logic             rx_beat = 1'b0;
    logic [2:0]       mode_sel;
    logic             flush;
    logic             rx_en;
    logic             tx_en;
    logic             busy;
    logic [LEN_W-1:0] tx_count;
    logic [LEN_W-1:0] rx_count;
    logic             done_pulse;
    logic             timeout_pulse;
    logic             overrun_pulse;
    logic             cfg_err_pulse;
    logic [2:0]       state_o;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_fail = 0;
    int  g_txc = 0;
    int  g_rxc = 0;
    ev_t exp_q[$];

    gyro_loop_sequencer #(
        .LEN_W(LEN_W), .FLUSH_CYC(FLUSH_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .restart(restart),
        .cfg_mode(cfg_mode), .cfg_len(cfg_len), .tx_beat(tx_beat), .rx_beat(rx_beat),
        .mode_sel(mode_sel), .flush(flush), .rx_en(rx_en), .tx_en(tx_en), .busy(busy),
        .tx_count(tx_count), .rx_count(rx_count), .done_pulse(done_pulse),
        .timeout_pulse(timeout_pulse), .overrun_pulse(overrun_pulse),
        .cfg_err_pulse(cfg_err_pulse), .state_o(state_o)
    );

    always #5 ACLK = ~ACLK;

    // Edge number: value seen after a posedge is the index of that edge
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic void push(input int k, input int e, input int t, input int r);
        ev_t v;
        v.kind = k; v.edge_n = e; v.txc = t; v.rxc = r;
        exp_q.push_back(v);
    endfunction

    task automatic mon_evt(input int kind);
        ev_t ev;
        logic [63:0] a;
        logic [63:0] x;
        a = {4'(kind), 28'(cyc), tx_count, rx_count};
        if (exp_q.size() == 0) begin
            chk("unexpected_event", a, 64'(0));
        end else begin
            ev = exp_q.pop_front();
            x = {4'(ev.kind), 28'(ev.edge_n), 16'(ev.txc), 16'(ev.rxc)};
            chk("event", a, x);
        end
    endtask

    // Monitor: every pulse must match the head of the expected-event queue
    always @(negedge ACLK) begin
        if (overrun_pulse) mon_evt(EV_OVR);
        if (done_pulse)    mon_evt(EV_DONE);
        if (timeout_pulse) mon_evt(EV_TO);
        if (cfg_err_pulse) mon_evt(EV_CERR);
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // One run with random beats; the model tracks word counts and event edges
    task automatic run_seq(input logic [2:0] mode, input int len, input bit via_restart,
                           input int rst_at_tx, input int new_len, input bit with_start,
                           input int rx_limit, input bit late_last, input int ovr_extra);
        int s_e, l_n, txc, rxc, tl, last_act, novr, e, guard, fin_kind, quiet_ref;
        bit rs_done, txb, rxb;
        logic [2:0] cur_mode;
        s_e = cyc + 1; l_n = len; txc = 0; rxc = 0; tl = -1; last_act = 0;
        novr = 0; fin_kind = 0; rs_done = 1'b0; cur_mode = mode; guard = 0;
        cfg_mode = mode;
        cfg_len  = LEN_W'(len);
        if (via_restart) restart = 1'b1; else start = 1'b1;
        step();
        start = 1'b0; restart = 1'b0;
        while (fin_kind == 0 && guard < 20000) begin
            guard++;
            if (cyc == s_e)
                chk("launch", 64'({flush, rx_en, tx_en, busy, mode_sel, tx_count, rx_count}),
                    64'({1'b1, 1'b0, 1'b0, 1'b1, cur_mode, 16'd0, 16'd0}));
            else if (cyc < s_e + FLUSH_CYC)
                chk("flush_hold", 64'({flush, rx_en, tx_en}), 64'(3'b100));
            else if (cyc == s_e + FLUSH_CYC)
                chk("arm_rx_first", 64'({flush, rx_en, tx_en}), 64'(3'b010));
            else if (cyc == s_e + FLUSH_CYC + 1)
                chk("run_enables", 64'({flush, rx_en, tx_en}), 64'(3'b011));
            else if (cyc == tl)
                chk("drain_enables", 64'({flush, rx_en, tx_en, state_o}), 64'({3'b010, 3'd4}));

            e = cyc + 1;
            cfg_mode = 3'($urandom_range(0, 7));
            cfg_len  = LEN_W'($urandom_range(0, 40));
            start    = ($urandom_range(0, 7) == 0);
            txb = 1'($urandom_range(0, 1));
            rxb = 1'($urandom_range(0, 1));
            if (rst_at_tx > 0 && !rs_done && txc == rst_at_tx) begin
                restart = 1'b1; start = with_start;
                cfg_mode = mode; cfg_len = LEN_W'(new_len);
                rs_done = 1'b1; s_e = e; l_n = new_len;
                txc = 0; rxc = 0; tl = -1; last_act = 0; novr = 0;
            end else begin
                quiet_ref = (tl > last_act) ? tl : last_act;
                if (novr < ovr_extra) txb = 1'b0;
                if (rxc >= rx_limit) rxb = 1'b0;
                if (late_last && rxc == l_n - 1)
                    rxb = (tl >= 0 && e > tl && e - quiet_ref == TIMEOUT_CYC);
                if (txb && e >= s_e + FLUSH_CYC + 2 && tl < 0) begin
                    txc++;
                    if (txc == l_n) tl = e;
                end
                if (rxb && e >= s_e + FLUSH_CYC + 1) begin
                    if (rxc == l_n) begin
                        push(EV_OVR, e, txc, rxc);
                        novr++;
                    end else begin
                        rxc++;
                    end
                    last_act = e;
                end
                quiet_ref = (tl > last_act) ? tl : last_act;
                if (tl >= 0 && e > tl) begin
                    if (rxc == l_n) begin
                        push(EV_DONE, e, txc, rxc);
                        fin_kind = EV_DONE;
                    end else if (e - quiet_ref == TIMEOUT_CYC) begin
                        push(EV_TO, e, txc, rxc);
                        fin_kind = EV_TO;
                    end
                end
            end
            tx_beat = txb;
            rx_beat = rxb;
            step();
            restart = 1'b0; start = 1'b0;
        end
        tx_beat = 1'b0; rx_beat = 1'b0;
        if (fin_kind == EV_TO) begin
            chk("idle_after_timeout", 64'({busy, state_o, rx_en, tx_en, tx_count, rx_count}),
                64'({1'b0, 3'd0, 2'b00, 16'(txc), 16'(rxc)}));
        end else begin
            step();
            chk("idle_after_done", 64'({busy, state_o, rx_en, tx_en, tx_count, rx_count}),
                64'({1'b0, 3'd0, 2'b00, 16'(txc), 16'(rxc)}));
        end
        g_txc = txc; g_rxc = rxc;
    endtask

    task automatic bad_start(input logic [2:0] mode, input int len, input bit via_restart);
        cfg_mode = mode;
        cfg_len  = LEN_W'(len);
        if (via_restart) restart = 1'b1; else start = 1'b1;
        push(EV_CERR, cyc + 1, g_txc, g_rxc);
        step();
        start = 1'b0; restart = 1'b0;
        chk("cfg_err_stays_idle", 64'({busy, state_o, flush, rx_en}), 64'(0));
        step();
    endtask

    initial begin
        repeat (3) step();
        chk("reset_zero", 64'({mode_sel, flush, rx_en, tx_en, busy, tx_count, rx_count,
            done_pulse, timeout_pulse, overrun_pulse, cfg_err_pulse, state_o}), 64'(0));
        ARESET = 1'b0;
        step();

        run_seq(3'd1, 4, 1'b0, 0, 0, 1'b0, 1000, 1'b0, 0);
        for (int i = 0; i < 4; i++)
            run_seq(3'($urandom_range(0, 5)), $urandom_range(1, 12), 1'b0, 0, 0, 1'b0,
                    1000, 1'b0, 0);
        run_seq(3'd0, 8, 1'b0, 0, 0, 1'b0, 5, 1'b0, 0);
        run_seq(3'd2, 16, 1'b0, 7, 32, 1'b0, 1000, 1'b0, 0);
        run_seq(3'd3, 10, 1'b0, 3, 6, 1'b1, 1000, 1'b0, 0);
        run_seq(3'd4, 2, 1'b0, 0, 0, 1'b0, 1000, 1'b0, 1);
        run_seq(3'd5, 3, 1'b0, 0, 0, 1'b0, 1000, 1'b1, 0);
        bad_start(3'd1, 0, 1'b0);
        bad_start(3'd7, 5, 1'b0);
        bad_start(3'd6, 3, 1'b1);
        run_seq(3'd0, 5, 1'b1, 0, 0, 1'b0, 1000, 1'b0, 0);

        cfg_mode = 3'd2; cfg_len = LEN_W'(5); start = 1'b1;
        step();
        start = 1'b0;
        repeat (FLUSH_CYC + 2) step();
        chk("pre_reset_run", 64'({tx_en, rx_en, state_o}), 64'({1'b1, 1'b1, 3'd3}));
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        chk("reset_in_run", 64'({mode_sel, flush, rx_en, tx_en, busy, tx_count, rx_count,
            done_pulse, timeout_pulse, overrun_pulse, cfg_err_pulse, state_o}), 64'(0));
        g_txc = 0; g_rxc = 0;

        repeat (4) step();
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gyro_loop_sequencer.md
Name: gyro_loop_sequencer

Overview:
Run controller for the gyro tester DTX/DRX datapath. It latches a loop configuration and word count, then flushes the TX/RX FIFOs. It enables the receive path before the transmit path and counts transmitted and received words. It finishes with done, timeout or overrun status for the IRQ register, and supports restart mid-run. It sits between the AXI-lite register block and the TX serializer, the RX deserializer and the loopback muxes.

Parameters:
LEN_W, 16, width of word-count config and counters
FLUSH_CYC, 8, cycles the flush output is held high
TIMEOUT_CYC, 4096, maximum cycles in DRAIN with no RX beat before timeout
TO_W, 13, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC

Ports:
ACLK  in  1  system clock
ARESET  in  1  synchronous active-high reset
start  in  1  1-cycle pulse, begin run
restart  in  1  1-cycle pulse, abort the current run and rerun with the current config
cfg_mode  in  3  0=loop1, 1=loop2, 2=loop3, 3=loop2 rx-bypass, 4=loop3 rx-bypass, 5=tx-pattern, 6/7 reserved
cfg_len  in  LEN_W  number of 32-bit words per run
tx_beat  in  1  one TX word accepted by the serializer this cycle
rx_beat  in  1  one RX word written by the deserializer this cycle
mode_sel  out  3  latched mode to the loopback muxes
flush  out  1  FIFO/serdes flush
rx_en  out  1  receive path enable
tx_en  out  1  transmit path enable
busy  out  1  state != IDLE
tx_count  out  LEN_W  words sent in the current run
rx_count  out  LEN_W  words received in the current run
done_pulse  out  1  1-cycle pulse, run complete
timeout_pulse  out  1  1-cycle pulse, DRAIN timeout
overrun_pulse  out  1  1-cycle pulse, RX word beyond cfg_len
cfg_err_pulse  out  1  1-cycle pulse, start/restart with bad config
state_o  out  3  current state encoding, for debug

Behaviour:
- Clocking and reset:
  - All logic on the ACLK rising edge.
  - ARESET high forces state IDLE; all outputs and counters 0, mode_sel=0. It overrides every other input.
- State encoding: IDLE=0, FLUSH=1, ARM=2, RUN=3, DRAIN=4, DONE=5.
- IDLE:
  - start with cfg_len!=0 and cfg_mode<=5: latch cfg_mode to mode_sel and cfg_len to len_r, clear both counts, go FLUSH next cycle.
  - start with cfg_len==0 or cfg_mode>=6: cfg_err_pulse next cycle, stay IDLE, no latch.
  - restart in IDLE behaves as start.
- FLUSH:
  - flush=1 for exactly FLUSH_CYC cycles; rx_en=tx_en=0.
  - Then ARM.
- ARM:
  - rx_en=1 for exactly 1 cycle; tx_en=0.
  - Then RUN.
- RUN:
  - rx_en=1, tx_en=1.
  - tx_count increments on tx_beat.
  - When tx_count reaches len_r (last beat counted), tx_en drops the next cycle and the state goes DRAIN.
  - tx_beat while tx_en=0 is ignored.
- Counting rules, all active states:
  - rx_count increments on rx_beat while rx_en=1; rx_beat with rx_en=0 is ignored.
  - An rx_beat when rx_count==len_r does not increment rx_count (saturates) and raises overrun_pulse; the run continues.
- DRAIN:
  - rx_en=1, tx_en=0.
  - The idle counter resets on every rx_beat.
  - rx_count==len_r goes to DONE.
  - Idle counter reaching TIMEOUT_CYC raises timeout_pulse and goes IDLE with enables low; counts are kept for readback.
- DONE:
  - done_pulse=1 for 1 cycle, rx_en=0, go IDLE. Counts are held until the next start.
- Simultaneous events:
  - The last rx_beat and the timeout expiring in the same cycle resolve as DONE; there is no timeout_pulse.
  - restart has priority over start and over all state transitions.
- restart in FLUSH, ARM, RUN or DRAIN:
  - tx_en=rx_en=0 the next cycle and both counts clear.
  - Config is re-latched from the current cfg_mode/cfg_len and the state goes FLUSH, which restarts the full FLUSH_CYC count.
  - No done or timeout pulse is issued for the aborted run.
  - If the re-latched config is invalid: cfg_err_pulse, state IDLE.
- start in any non-IDLE state is ignored.
- cfg_mode and cfg_len changes after the latch have no effect until the next start or restart.
- Counter width: LEN_W bits with no wrap (bounded by len_r). The timeout counter saturates at TIMEOUT_CYC.

Test Plan:
- Nominal run: cfg_mode=1, cfg_len=4, start. Flush high 8 cycles, then rx_en 1 cycle ahead of tx_en. 4 tx_beats, tx_en falls the cycle after the 4th. 4 rx_beats give done_pulse; tx_count=rx_count=4; busy falls the cycle after done_pulse.
- Timeout: cfg_len=8, 8 tx_beats, 5 rx_beats, then silence. timeout_pulse exactly 4096 cycles after the last rx_beat; rx_count=5; state IDLE; no done_pulse.
- Restart mid-RUN: cfg_len=16, restart after 7 tx_beats with cfg_len changed to 32. Enables drop next cycle, counts clear, flush 8 cycles. The new run completes at 32 words with a single done_pulse.
- Overrun: cfg_len=2, 3 rx_beats during RUN/DRAIN. overrun_pulse on the 3rd; rx_count stays at 2; done_pulse still issued.
- Config errors: start with cfg_len=0 gives cfg_err_pulse and busy stays 0. Start with cfg_mode=7 gives the same. ARESET asserted during RUN zeroes all outputs on the next edge.
- Simultaneous events: last rx_beat and timeout expiry in the same cycle give done_pulse only. start and restart pulsed together in RUN are treated as restart.
